// File: rtl/mu_pkg.sv
// Shared definitions for the RV32M multiply unit: operation encodings,
// widths, pipeline depth and operand-extension helpers.
package mu_pkg;

  localparam int XLEN       = 32;
  localparam int MU_LATENCY = 3;

  localparam logic [1:0] MULCTL_MUL    = 2'b00;
  localparam logic [1:0] MULCTL_MULH   = 2'b01;
  localparam logic [1:0] MULCTL_MULHSU = 2'b10;
  localparam logic [1:0] MULCTL_MULHU  = 2'b11;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [1:0]      ctl;
  } mu_op_t;

  // rs1 is treated as signed for everything except MULHU.
  function automatic logic [XLEN:0] ext_a(input logic [XLEN-1:0] a, input logic [1:0] ctl);
    return {(ctl != MULCTL_MULHU) & a[XLEN-1], a};
  endfunction

  // rs2 is signed only for MUL and MULH (ctl[1] clear).
  function automatic logic [XLEN:0] ext_b(input logic [XLEN-1:0] b, input logic [1:0] ctl);
    return {~ctl[1] & b[XLEN-1], b};
  endfunction

endpackage

// File: rtl/mu_booth_pp_tree.sv
// Combinational NxN signed radix-4 Booth partial-product generator with a
// carry-save reduction down to a sum/carry pair (exact modulo 2^PW).
module booth_pp_tree #(
  parameter int N  = 33,
  parameter int PW = 2 * N
) (
  input  logic [N-1:0]  x,
  input  logic [N-1:0]  y,
  output logic [PW-1:0] sum,
  output logic [PW-1:0] carry
);

  localparam int ND = (N + 2) / 2;  // Booth digits over y sign-extended to even width
  localparam int NR = ND + 1;       // digit rows plus one row of negation corrections

  logic [2*ND:0]  y_ext;
  logic [PW-1:0]  x_s;
  logic [PW-1:0]  x2_s;
  logic [ND-1:0]  neg;
  logic [PW-1:0]  rows [NR];
  logic [PW-1:0]  s_chain [NR-1];
  logic [PW-1:0]  c_chain [NR-1];

  assign y_ext = {{(2*ND-N){y[N-1]}}, y, 1'b0};
  assign x_s   = {{(PW-N){x[N-1]}}, x};
  assign x2_s  = x_s << 1;

  generate
    for (genvar gi = 0; gi < ND; gi++) begin : g_digit
      logic [2:0]    trip;
      logic          one;
      logic          two;
      logic [PW-1:0] mag;

      assign trip = y_ext[2*gi+2 : 2*gi];
      assign one  = trip[0] ^ trip[1];
      assign two  = (trip == 3'b011) | (trip == 3'b100);
      // 3'b111 encodes -0, so it must not request a +1 correction.
      assign neg[gi] = trip[2] & ~(trip[1] & trip[0]);
      assign mag  = one ? x_s : (two ? x2_s : '0);
      assign rows[gi] = (neg[gi] ? ~mag : mag) << (2 * gi);
    end
  endgenerate

  always_comb begin
    rows[NR-1] = '0;
    for (int i = 0; i < ND; i++) begin
      rows[NR-1][2*i] = neg[i];
    end
  end

  assign s_chain[0] = rows[0];
  assign c_chain[0] = rows[1];

  generate
    for (genvar gi = 1; gi < NR - 1; gi++) begin : g_csa
      assign s_chain[gi] = s_chain[gi-1] ^ c_chain[gi-1] ^ rows[gi+1];
      assign c_chain[gi] = ((s_chain[gi-1] & c_chain[gi-1]) |
                            (s_chain[gi-1] & rows[gi+1])    |
                            (c_chain[gi-1] & rows[gi+1])) << 1;
    end
  endgenerate

  assign sum   = s_chain[NR-2];
  assign carry = c_chain[NR-2];

endmodule

// File: rtl/mu_unit.sv
// Three-stage pipelined RV32M multiplier (MUL/MULH/MULHSU/MULHU):
// register operands, Booth/CSA reduce, then final add and high/low select.
module mu_unit
  import mu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int LATENCY = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [1:0]      mulctl,
  output logic [XLEN-1:0] mulres
);

  generate
    if (XLEN != mu_pkg::XLEN || LATENCY != MU_LATENCY) begin : g_bad_param
      $error("mu_unit supports only XLEN=32 and LATENCY=3");
    end
  endgenerate

  // Only the low 64 bits of the 66-bit product can ever be selected, so the
  // reduction is carried out modulo 2^64.
  localparam int PW = 2 * XLEN;

  mu_op_t          op_reg;
  mu_op_t          op_next;
  logic [XLEN:0]   a_ext;
  logic [XLEN:0]   b_ext;
  logic [PW-1:0]   pp_sum;
  logic [PW-1:0]   pp_carry;
  logic [PW-1:0]   sum_reg;
  logic [PW-1:0]   carry_reg;
  logic [1:0]      ctl2_reg;
  logic [PW-1:0]   prod;
  logic [XLEN-1:0] mulres_reg;
  logic [XLEN-1:0] mulres_next;

  assign op_next = '{a: a, b: b, ctl: mulctl};

  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg <= '0;
    end else begin
      op_reg <= op_next;
    end
  end

  assign a_ext = ext_a(op_reg.a, op_reg.ctl);
  assign b_ext = ext_b(op_reg.b, op_reg.ctl);

  booth_pp_tree #(
    .N  (XLEN + 1),
    .PW (PW)
  ) u_pp_tree (
    .x     (a_ext),
    .y     (b_ext),
    .sum   (pp_sum),
    .carry (pp_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_reg   <= '0;
      carry_reg <= '0;
      ctl2_reg  <= MULCTL_MUL;
    end else begin
      sum_reg   <= pp_sum;
      carry_reg <= pp_carry;
      ctl2_reg  <= op_reg.ctl;
    end
  end

  assign prod        = sum_reg + carry_reg;
  assign mulres_next = (ctl2_reg == MULCTL_MUL) ? prod[XLEN-1:0] : prod[PW-1:XLEN];

  always_ff @(posedge clk) begin
    if (rst) begin
      mulres_reg <= '0;
    end else begin
      mulres_reg <= mulres_next;
    end
  end

  assign mulres = mulres_reg;

endmodule

// File: tb/tb_mu_unit.sv
// Directed and streamed checks of mu_unit: reset, small and corner operands,
// random back-to-back traffic, and reset with operations in flight.
module tb_mu_unit;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  mulctl;
  logic [31:0] mulres;

  int checks = 0;
  int errors = 0;

  mu_unit dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .mulctl (mulctl),
    .mulres (mulres)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 64-bit reference: extend each operand per op, multiply, select half.
  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input logic [1:0] c);
    logic [63:0] xe;
    logic [63:0] ye;
    logic [63:0] p;
    xe = (c != 2'b11 && x[31]) ? {32'hFFFF_FFFF, x} : {32'h0, x};
    ye = (c[1] == 1'b0 && y[31]) ? {32'hFFFF_FFFF, y} : {32'h0, y};
    p  = xe * ye;
    return (c == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic test_reset();
    rst = 1'b1; a = 32'hDEAD_BEEF; b = 32'h1234_5678; mulctl = 2'b01;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (mulres !== 32'h0) begin
        errors++;
        $display("FAIL reset_hold[%0d] mulres=%08h expected=%08h", i, mulres, 32'h0);
      end
    end
    rst = 1'b0; a = '0; b = '0; mulctl = 2'b00;
    $display("test_reset done");
  endtask

  task automatic test_small_ops();
    logic [1:0]  ctl [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [31:0] ex  [4] = '{32'd12, 32'd0, 32'd0, 32'd0};
    for (int t = 0; t < 7; t++) begin
      @(negedge clk);
      if (t >= 3) begin
        checks++;
        if (mulres !== ex[t-3]) begin
          errors++;
          $display("FAIL small[%0d] ctl=%0d mulres=%08h expected=%08h", t-3, ctl[t-3], mulres, ex[t-3]);
        end else begin
          $display("small[%0d] ctl=%0d mulres=%08h", t-3, ctl[t-3], mulres);
        end
      end
      if (t < 4) begin
        a = 32'd3; b = 32'd4; mulctl = ctl[t];
      end else begin
        a = '0; b = '0; mulctl = 2'b00;
      end
    end
  endtask

  task automatic test_corners();
    logic [31:0] va [12] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                             32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678};
    logic [31:0] vb [12] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                             32'h9ABC_DEF0, 32'h9ABC_DEF0, 32'h9ABC_DEF0, 32'h9ABC_DEF0};
    logic [1:0]  vc [12] = '{2'b00, 2'b01, 2'b10, 2'b11,
                             2'b00, 2'b01, 2'b10, 2'b11,
                             2'b00, 2'b11, 2'b01, 2'b10};
    logic [31:0] ex [12] = '{32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
                             32'h0000_0000, 32'h4000_0000, 32'hC000_0000, 32'h4000_0000,
                             32'h242D_2080, 32'h0B00_EA4E, 32'hF8CC_93D6, 32'h0B00_EA4E};
    for (int t = 0; t < 15; t++) begin
      @(negedge clk);
      if (t >= 3) begin
        checks++;
        if (mulres !== ex[t-3]) begin
          errors++;
          $display("FAIL corner[%0d] a=%08h b=%08h ctl=%0d mulres=%08h expected=%08h",
                   t-3, va[t-3], vb[t-3], vc[t-3], mulres, ex[t-3]);
        end else begin
          $display("corner[%0d] a=%08h b=%08h ctl=%0d mulres=%08h", t-3, va[t-3], vb[t-3], vc[t-3], mulres);
        end
      end
      if (t < 12) begin
        a = va[t]; b = vb[t]; mulctl = vc[t];
      end else begin
        a = '0; b = '0; mulctl = 2'b00;
      end
    end
  endtask

  // Random ops every cycle, operands biased towards corner values; each
  // result must emerge exactly three cycles after issue, in order.
  task automatic test_back_to_back();
    localparam int NOPS = 4400;
    logic [31:0] corner [5] = '{32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h1};
    logic [31:0] exq [$];
    logic [31:0] exp_v;
    logic [31:0] x;
    logic [31:0] y;
    int          nerr = 0;
    for (int t = 0; t < NOPS + 3; t++) begin
      @(negedge clk);
      if (t >= 3) begin
        exp_v = exq.pop_front();
        checks++;
        if (mulres !== exp_v) begin
          errors++;
          nerr++;
          $display("FAIL stream[%0d] mulres=%08h expected=%08h", t-3, mulres, exp_v);
        end
      end
      if (t < NOPS) begin
        x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
        y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
        a = x; b = y; mulctl = 2'(t % 4 == 0 ? $urandom_range(0, 3) : t % 4);
        exq.push_back(ref_mul(x, y, mulctl));
      end else begin
        a = '0; b = '0; mulctl = 2'b00;
      end
    end
    $display("stream ops=%0d errors=%0d", NOPS, nerr);
  endtask

  task automatic test_reset_in_flight();
    // t0: 5*7 MUL, t1: all-ones MULHU, t2: reset + 3*3 MUL, t3: 6*7 MUL
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (t >= 3 && t <= 5) begin
        checks++;
        if (mulres !== 32'h0) begin
          errors++;
          $display("FAIL flush[%0d] mulres=%08h expected=%08h", t, mulres, 32'h0);
        end else begin
          $display("flush[%0d] mulres=%08h", t, mulres);
        end
      end
      if (t == 6) begin
        checks++;
        if (mulres !== 32'd42) begin
          errors++;
          $display("FAIL post_reset mulres=%08h expected=%08h", mulres, 32'd42);
        end else begin
          $display("post_reset mulres=%08h", mulres);
        end
      end
      rst = 1'b0;
      case (t)
        0: begin a = 32'd5;         b = 32'd7;         mulctl = 2'b00; end
        1: begin a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; mulctl = 2'b11; end
        2: begin a = 32'd3;         b = 32'd3;         mulctl = 2'b00; rst = 1'b1; end
        3: begin a = 32'd6;         b = 32'd7;         mulctl = 2'b00; end
        default: begin a = '0; b = '0; mulctl = 2'b00; end
      endcase
    end
  endtask

  initial begin
    rst = 1'b1; a = '0; b = '0; mulctl = 2'b00;
    test_reset();
    test_small_ops();
    test_corners();
    test_back_to_back();
    test_reset_in_flight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
